// File: rtl/truth_table_if.sv
// ---------------------------------------------------------------------------
// truth_table_if
//   Bundle between the truth-table sequencer, the combinational function
//   block it exercises, and the consumer of captured rows.
//
//   Control      : start, abort
//   Block drive  : w, x, y, z   ({w,x,y,z} = row index being applied)
//   Block return : f_in[9:0]    (f_in[k] = fk)
//   Row stream   : row_valid, row_ready, row_index[3:0], row_outputs[9:0]
//   Status       : busy, done, signature[9:0]
//
//   master : the sequencer side
//   slave  : the environment side (controller, function block, consumer)
// ---------------------------------------------------------------------------
interface truth_table_if;
  logic       start;
  logic       abort;
  logic       w;
  logic       x;
  logic       y;
  logic       z;
  logic [9:0] f_in;
  logic       row_valid;
  logic       row_ready;
  logic [3:0] row_index;
  logic [9:0] row_outputs;
  logic       busy;
  logic       done;
  logic [9:0] signature;

  modport master (
    input  start, abort, f_in, row_ready,
    output w, x, y, z, row_valid, row_index, row_outputs, busy, done, signature
  );

  modport slave (
    output start, abort, f_in, row_ready,
    input  w, x, y, z, row_valid, row_index, row_outputs, busy, done, signature
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer
//   Walks a 4-input / 10-output combinational block through rows
//   0..LAST_ROW. Each row is driven on {w,x,y,z}, left to settle for
//   SETTLE_CYCLES clocks, captured from f_in and offered on a valid/ready
//   stream. Every accepted row is folded into a rotate-XOR signature.
//
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : truth_table_if.master (start/abort, w..z, f_in, row stream,
//          busy, done, signature)
//
//   Parameters
//     SETTLE_CYCLES : clocks from driving a row to capturing f_in (1..15)
//     LAST_ROW      : final row index of a sweep
// ---------------------------------------------------------------------------
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 3,
  parameter int LAST_ROW      = 15
) (
  input  logic                clk,
  input  logic                rst,
  truth_table_if.master       bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // The counter is loaded with SETTLE_CYCLES-1 on the drive edge and the
  // capture happens on the edge where it is already zero, which puts the
  // capture exactly SETTLE_CYCLES edges after the drive.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_IDX    = 4'(LAST_ROW);

  state_t     state_reg,       state_next;
  logic [3:0] idx_reg,         idx_next;
  logic [3:0] settle_cnt_reg,  settle_cnt_next;
  logic [3:0] drive_reg,       drive_next;
  logic       row_valid_reg,   row_valid_next;
  logic [3:0] row_index_reg,   row_index_next;
  logic [9:0] row_outputs_reg, row_outputs_next;
  logic [9:0] signature_reg,   signature_next;

  logic       handshake;
  assign handshake = row_valid_reg & bus.row_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      settle_cnt_reg  <= '0;
      drive_reg       <= '0;
      row_valid_reg   <= 1'b0;
      row_index_reg   <= '0;
      row_outputs_reg <= '0;
      signature_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      settle_cnt_reg  <= settle_cnt_next;
      drive_reg       <= drive_next;
      row_valid_reg   <= row_valid_next;
      row_index_reg   <= row_index_next;
      row_outputs_reg <= row_outputs_next;
      signature_reg   <= signature_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    settle_cnt_next  = settle_cnt_reg;
    drive_next       = drive_reg;
    row_valid_next   = row_valid_reg;
    row_index_next   = row_index_reg;
    row_outputs_next = row_outputs_reg;
    signature_next   = signature_reg;

    if (bus.abort) begin
      // Abort outranks start and handshake: the presented row is dropped
      // unaccepted, so the signature and the last driven/captured values
      // are left as they are.
      state_next     = ST_IDLE;
      row_valid_next = 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            idx_next        = '0;
            drive_next      = '0;
            settle_cnt_next = SETTLE_LOAD;
            signature_next  = '0;
            state_next      = ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_reg == 4'd0) begin
            row_outputs_next = bus.f_in;
            row_index_next   = idx_reg;
            row_valid_next   = 1'b1;
            state_next       = ST_PRESENT;
          end else begin
            settle_cnt_next = settle_cnt_reg - 4'd1;
          end
        end

        ST_PRESENT: begin
          if (handshake) begin
            signature_next = {signature_reg[8:0], signature_reg[9]} ^ row_outputs_reg;
            row_valid_next = 1'b0;
            if (idx_reg == LAST_IDX) begin
              state_next = ST_DONE;
            end else begin
              // The next row goes onto the block on the handshake edge
              // itself, so settling overlaps nothing the consumer sees.
              idx_next        = idx_reg + 4'd1;
              drive_next      = idx_reg + 4'd1;
              settle_cnt_next = SETTLE_LOAD;
              state_next      = ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.w           = drive_reg[3];
  assign bus.x           = drive_reg[2];
  assign bus.y           = drive_reg[1];
  assign bus.z           = drive_reg[0];
  assign bus.row_valid   = row_valid_reg;
  assign bus.row_index   = row_index_reg;
  assign bus.row_outputs = row_outputs_reg;
  assign bus.signature   = signature_reg;
  assign bus.busy        = (state_reg == ST_SETTLE) || (state_reg == ST_PRESENT);
  assign bus.done        = (state_reg == ST_DONE);

endmodule
